// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MFHI    = 4'd7,
        MFLO    = 4'd8
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;
    localparam int MD_CNT_W    = 4;

    // True for the ops that occupy the unit for a multi-cycle window.
    function automatic logic is_md_arith(md_op_e op);
        return op inside {MULT, MULTU, DIV, DIVU};
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E-stage <-> MD unit signal bundle. master = pipeline side, slave = MD unit.
interface md_sequencer_if;
    import md_pkg::*;

    md_op_e      e_md_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md_use;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] md_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output e_md_op, e_rs, e_rt, d_md_use,
        input  start, busy, md_stall, md_rdata, hi, lo
    );

    modport slave (
        input  e_md_op, e_rs, e_rt, d_md_use,
        output start, busy, md_stall, md_rdata, hi, lo
    );

endinterface

// File: rtl/md_arith.sv
// Single-cycle HI/LO result computation for mult/multu/div/divu.
// Non-arithmetic ops and divide-by-zero pass the current HI/LO through, so a
// later commit leaves the architectural registers untouched.
module md_arith
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] qm;
    logic [31:0] rm;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic [31:0] rt_safe;
    logic        rt_zero;

    // Products: low 64 bits of sign-extended operands give the signed result.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Divisor forced to 1 on zero so the dividers never see x; the result is
    // discarded in that case anyway.
    assign rt_zero = (rt == 32'd0);
    assign rt_safe = rt_zero ? 32'd1 : rt;

    // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow corner,
    // which falls out naturally as |q| = 0x80000000 with a positive sign.
    assign a_mag = rs[31] ? (32'd0 - rs) : rs;
    assign b_mag = rt_safe[31] ? (32'd0 - rt_safe) : rt_safe;
    assign qm    = a_mag / b_mag;
    assign rm    = a_mag % b_mag;
    assign q_s   = (rs[31] ^ rt_safe[31]) ? (32'd0 - qm) : qm;
    assign r_s   = rs[31] ? (32'd0 - rm) : rm;

    assign q_u   = rs / rt_safe;
    assign r_u   = rs % rt_safe;

    // Result select by op.
    always_comb begin
        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            DIV: if (!rt_zero) begin
                res_hi = r_s;
                res_lo = q_s;
            end
            DIVU: if (!rt_zero) begin
                res_hi = r_u;
                res_lo = q_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide controller for the E stage: owns HI/LO, runs mult/div over a
// fixed latency, services mthi/mtlo/mfhi/mflo and raises the D-stage stall.
// The result is computed at start and held in pend_*; the counter only models
// the architectural latency.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT,
    parameter int CNT_W    = MD_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  md
);

    md_state_e        state;
    md_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             start_c;
    logic             busy_c;
    logic             last_c;

    md_arith u_arith (
        .op     (md.e_md_op),
        .rs     (md.e_rs),
        .rt     (md.e_rt),
        .cur_hi (hi_q),
        .cur_lo (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign busy_c = (state == RUN);
    assign last_c = busy_c && (cnt == CNT_W'(1));

    // Next-state, counter and start decode; start is gated by reset so the
    // stall never fires while the pipeline is being flushed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start_c   = 1'b0;
        case (state)
            IDLE: begin
                if (is_md_arith(md.e_md_op) && !reset) begin
                    start_c   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = (md.e_md_op inside {MULT, MULTU}) ?
                                CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                end
            end
            RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (last_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // HI/LO and pending result; moves are only honoured while idle, and a
    // reset mid-run drops the pending result along with HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            if (start_c) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end
            if (state == IDLE && md.e_md_op == MTHI) hi_q <= md.e_rs;
            if (state == IDLE && md.e_md_op == MTLO) lo_q <= md.e_rs;
            if (last_c) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end
    end

    // Move-from read port; not stalled here, D-stage stall covers hazards.
    always_comb begin
        md.md_rdata = 32'd0;
        if (md.e_md_op == MFHI) md.md_rdata = hi_q;
        else if (md.e_md_op == MFLO) md.md_rdata = lo_q;
    end

    assign md.start    = start_c;
    assign md.busy     = busy_c;
    assign md.md_stall = !reset && md.d_md_use && (start_c || busy_c);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: expected HI/LO pushed at issue, popped and
// compared when busy falls.
module tb_md_sequencer;
    import md_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] sb[$];

    md_sequencer_if ifc ();

    md_sequencer #(.MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input md_op_e op, input logic [31:0] v);
        cyc();
        ifc.e_md_op = op;
        ifc.e_rs = v;
        @(negedge clk);
        chk("mt_start", 32'(ifc.start), 32'd0);
        cyc();
        ifc.e_md_op = MD_NONE;
        if (op == MTHI) m_hi = v; else m_lo = v;
        @(negedge clk);
        chk("mt_hi", ifc.hi, m_hi);
        chk("mt_lo", ifc.lo, m_lo);
    endtask

    task automatic run_op(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int lat, input logic use_d, input logic noise);
        logic [63:0] e;
        cyc();
        ifc.e_md_op = op;
        ifc.e_rs = rs;
        ifc.e_rt = rt;
        ifc.d_md_use = use_d;
        @(negedge clk);
        chk("start", 32'(ifc.start), 32'd1);
        chk("stall_start", 32'(ifc.md_stall), 32'(use_d));
        sb.push_back({eh, el});
        for (int k = 1; k <= lat; k++) begin
            cyc();
            ifc.e_md_op = noise ? MTLO : MD_NONE;
            ifc.e_rs = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("busy", 32'(ifc.busy), 32'd1);
            chk("stall_busy", 32'(ifc.md_stall), 32'(use_d));
            if (k == lat) begin
                chk("hi_before_commit", ifc.hi, m_hi);
                chk("lo_before_commit", ifc.lo, m_lo);
            end
        end
        cyc();
        ifc.e_md_op = MD_NONE;
        @(negedge clk);
        chk("busy_end", 32'(ifc.busy), 32'd0);
        chk("stall_end", 32'(ifc.md_stall), 32'd0);
        if (ifc.busy == 1'b0) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("hi", ifc.hi, e[63:32]);
                chk("lo", ifc.lo, e[31:0]);
                m_hi = e[63:32];
                m_lo = e[31:0];
            end
        end
        ifc.d_md_use = 1'b0;
    endtask

    initial begin
        ifc.e_md_op = MULT;
        ifc.e_rs = 32'd3;
        ifc.e_rt = 32'd4;
        ifc.d_md_use = 1'b1;
        // Reset: start/stall gated even with an arithmetic op and D use present.
        @(negedge clk);
        chk("rst_start", 32'(ifc.start), 32'd0);
        chk("rst_stall", 32'(ifc.md_stall), 32'd0);
        cyc();
        reset = 1'b0;
        ifc.e_md_op = MFHI;
        ifc.d_md_use = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_hi", ifc.hi, 32'd0);
        chk("rst_lo", ifc.lo, 32'd0);
        chk("rst_rdata", ifc.md_rdata, 32'd0);

        // 1 + 4: signed mult with stall held across the whole window.
        run_op(MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, ML, 1'b1, 1'b0);
        // 2: divu then div, no D-stage use.
        run_op(DIVU, 32'd7, 32'hFFFF_FFFF, 32'd7, 32'd0, DL, 1'b0, 1'b0);
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DL, 1'b0, 1'b0);
        // Signed divide overflow corner.
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DL, 1'b0, 1'b0);
        // 3: divide by zero keeps moved values; moves issued while busy are dropped.
        mt(MTHI, 32'h0000_1234);
        mt(MTLO, 32'h0000_5678);
        run_op(DIV, 32'd5, 32'd0, 32'h0000_1234, 32'h0000_5678, DL, 1'b1, 1'b1);
        // 6: most-negative operands, signed and unsigned.
        run_op(MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, ML, 1'b0, 1'b0);
        run_op(MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, ML, 1'b0, 1'b0);
        cyc();
        ifc.e_md_op = MFHI;
        @(negedge clk);
        chk("mfhi_rdata", ifc.md_rdata, 32'h4000_0000);
        cyc();
        ifc.e_md_op = MD_NONE;
        @(negedge clk);
        chk("none_rdata", ifc.md_rdata, 32'd0);

        // 5: reset in the middle of a mult.
        mt(MTLO, 32'h0000_0055);
        cyc();
        ifc.e_md_op = MULT;
        ifc.e_rs = 32'd3;
        ifc.e_rt = 32'd5;
        ifc.d_md_use = 1'b1;
        @(negedge clk);
        chk("r5_start", 32'(ifc.start), 32'd1);
        for (int k = 1; k <= 2; k++) begin
            cyc();
            ifc.e_md_op = MD_NONE;
            @(negedge clk);
            chk("r5_busy", 32'(ifc.busy), 32'd1);
        end
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("r5_stall_in_reset", 32'(ifc.md_stall), 32'd0);
        cyc();
        reset = 1'b0;
        ifc.d_md_use = 1'b0;
        @(negedge clk);
        chk("r5_busy_clr", 32'(ifc.busy), 32'd0);
        chk("r5_hi", ifc.hi, 32'd0);
        chk("r5_lo", ifc.lo, 32'd0);
        cyc();
        ifc.e_md_op = MFLO;
        @(negedge clk);
        chk("r5_mflo", ifc.md_rdata, 32'd0);
        // The aborted mult must not commit later.
        for (int k = 0; k < ML + 2; k++) cyc();
        ifc.e_md_op = MD_NONE;
        @(negedge clk);
        chk("r5_lo_stays", ifc.lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
